// File: rtl/tffers_cmd_gen.sv
// tffers_cmd_gen
// Front-end command generator for the clear/set/toggle flip-flop.
//   * Two-flop synchronizer on each of the four raw board switches.
//   * Independent counter-based debouncer per switch; SW_DB exposes the
//     debounced levels, bit 0 being the strobe switch SW0.
//   * Two-state FSM (IDLE/HELD) that issues one registered, single-cycle,
//     priority-encoded command per debounced press of the strobe.
//     Priority: clear (SW1) > set (SW2) > toggle (SW3).
// Optional feature, enabled by defining TFFERS_AUTO_REPEAT_EN:
//   while the strobe stays held, the command is re-issued from the current
//   selector levels every REPEAT_CYCLES cycles. With the macro undefined
//   the repeat counter is not built and exactly one command is issued per press.
// All state is reset synchronously by RST_N low at a CLK rising edge.

module tffers_cmd_gen #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 20,
    parameter int REPEAT_CYCLES   = 64
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       SW0,
    input  logic       SW1,
    input  logic       SW2,
    input  logic       SW3,
    output logic       CMD_VALID,
    output logic       CMD_CLR,
    output logic       CMD_SET,
    output logic       CMD_TGL,
    output logic [3:0] SW_DB
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HELD = 1'b1;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Parameter sanity: a debounce window below two cycles would let a
    // single-cycle glitch through, and a zero repeat interval is meaningless.
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("tffers_cmd_gen: DEBOUNCE_CYCLES must be at least 2");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_repeat
        $error("tffers_cmd_gen: REPEAT_CYCLES must be at least 1");
    end

    // ------------------------------------------------------------------
    // Priority encoder: selector levels {SW3,SW2,SW1} -> one-hot
    // command {tgl,set,clr}. Clear wins over set, set wins over toggle;
    // all-zero selectors yield no command.
    // ------------------------------------------------------------------
    function automatic logic [2:0] encode_cmd(input logic [2:0] sel);
        logic [2:0] cmd;
        cmd = 3'b000;
        if (sel[0]) begin
            cmd = 3'b001;
        end else if (sel[1]) begin
            cmd = 3'b010;
        end else if (sel[2]) begin
            cmd = 3'b100;
        end else begin
            cmd = 3'b000;
        end
        return cmd;
    endfunction

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic [3:0]       raw_s;
    logic [3:0]       sync1_r;
    logic [3:0]       sync2_r;
    logic [3:0]       db_r;
    logic [3:0]       db_nxt_s;
    logic [CNT_W-1:0] db_cnt_r     [4];
    logic [CNT_W-1:0] db_cnt_nxt_s [4];

    logic [0:0]       state_r;
    logic [0:0]       state_nxt_s;
    logic             strobe_prev_r;
    logic             strobe_rise_s;
    logic             issue_s;
    logic [2:0]       cmd_s;

    logic             cmd_valid_r;
    logic             cmd_clr_r;
    logic             cmd_set_r;
    logic             cmd_tgl_r;

    assign raw_s = {SW3, SW2, SW1, SW0};

    // ------------------------------------------------------------------
    // Synchronizer
    // ------------------------------------------------------------------

    // Two-flop synchronizer bringing every raw switch into the CLK domain.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync1_r <= 4'b0000;
            sync2_r <= 4'b0000;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // ------------------------------------------------------------------
    // Debouncer
    // A switch's stable level only follows the synchronized level after
    // DEBOUNCE_CYCLES consecutive disagreeing samples; any sample that
    // agrees with the stable level restarts the count. The counter stops
    // at DB_LAST, so it can never wrap.
    // ------------------------------------------------------------------

    // Next-state decision for each switch's stable level and counter.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            db_nxt_s[i]     = db_r[i];
            db_cnt_nxt_s[i] = CNT_ZERO;
            if (sync2_r[i] == db_r[i]) begin
                db_cnt_nxt_s[i] = CNT_ZERO;
            end else if (db_cnt_r[i] < DB_LAST) begin
                db_cnt_nxt_s[i] = db_cnt_r[i] + CNT_ONE;
            end else begin
                db_nxt_s[i]     = sync2_r[i];
                db_cnt_nxt_s[i] = CNT_ZERO;
            end
        end
    end

    // Debounced levels and their counters.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            db_r <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                db_cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            db_r <= db_nxt_s;
            for (int i = 0; i < 4; i++) begin
                db_cnt_r[i] <= db_cnt_nxt_s[i];
            end
        end
    end

    assign SW_DB = db_r;

    // ------------------------------------------------------------------
    // Strobe edge detection
    // ------------------------------------------------------------------

    // Debounced strobe level as it stood at the previous edge.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            strobe_prev_r <= 1'b0;
        end else begin
            strobe_prev_r <= db_r[0];
        end
    end

    assign strobe_rise_s = db_r[0] & ~strobe_prev_r;

    // Command derived from selector levels as they stand at this edge.
    assign cmd_s = encode_cmd(db_r[3:1]);

`ifdef TFFERS_AUTO_REPEAT_EN
    // ------------------------------------------------------------------
    // Auto-repeat interval counter
    // Sits at zero outside HELD, so it is zero on the entry edge; the
    // repeat fires REPEAT_CYCLES edges after entry (or after the previous
    // repeat) while the strobe is still held.
    // ------------------------------------------------------------------
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic [CNT_W-1:0] rpt_cnt_r;
    logic             rpt_hit_s;

    assign rpt_hit_s = (rpt_cnt_r == RPT_LAST);

    // Repeat counter: runs only while HELD with the strobe still down.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rpt_cnt_r <= CNT_ZERO;
        end else if (state_r != ST_HELD) begin
            rpt_cnt_r <= CNT_ZERO;
        end else if (!db_r[0]) begin
            rpt_cnt_r <= CNT_ZERO;
        end else if (rpt_hit_s) begin
            rpt_cnt_r <= CNT_ZERO;
        end else begin
            rpt_cnt_r <= rpt_cnt_r + CNT_ONE;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Press FSM
    // ------------------------------------------------------------------

    // Next state and command-issue decision.
    always_comb begin
        state_nxt_s = state_r;
        issue_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (strobe_rise_s) begin
                    state_nxt_s = ST_HELD;
                    issue_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                    issue_s     = 1'b0;
                end
            end
            ST_HELD: begin
                if (!db_r[0]) begin
                    state_nxt_s = ST_IDLE;
                    issue_s     = 1'b0;
                end else begin
                    state_nxt_s = ST_HELD;
`ifdef TFFERS_AUTO_REPEAT_EN
                    issue_s     = rpt_hit_s;
`else
                    issue_s     = 1'b0;
`endif
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                issue_s     = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // ------------------------------------------------------------------
    // Command outputs
    // A press with no selector active still enters HELD but produces no
    // pulse; every command bit is forced low whenever CMD_VALID is low.
    // ------------------------------------------------------------------

    // Registered single-cycle command pulse.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cmd_valid_r <= 1'b0;
            cmd_clr_r   <= 1'b0;
            cmd_set_r   <= 1'b0;
            cmd_tgl_r   <= 1'b0;
        end else if (issue_s && (cmd_s != 3'b000)) begin
            cmd_valid_r <= 1'b1;
            cmd_clr_r   <= cmd_s[0];
            cmd_set_r   <= cmd_s[1];
            cmd_tgl_r   <= cmd_s[2];
        end else begin
            cmd_valid_r <= 1'b0;
            cmd_clr_r   <= 1'b0;
            cmd_set_r   <= 1'b0;
            cmd_tgl_r   <= 1'b0;
        end
    end

    assign CMD_VALID = cmd_valid_r;
    assign CMD_CLR   = cmd_clr_r;
    assign CMD_SET   = cmd_set_r;
    assign CMD_TGL   = cmd_tgl_r;

endmodule

// File: tb/tb_tffers_cmd_gen.sv
// Testbench for tffers_cmd_gen (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8).
// A reference model samples the raw switches at every rising edge, derives
// the debounced levels from the history of synchronized samples, and pushes
// each expected command into a scoreboard queue. A monitor on the falling
// edge compares SW_DB every cycle and pops/compares every command pulse.

module tb_tffers_cmd_gen;

    localparam int D = 4;
    localparam int R = 8;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       SW0, SW1, SW2, SW3;
    logic       CMD_VALID, CMD_CLR, CMD_SET, CMD_TGL;
    logic [3:0] SW_DB;

    tffers_cmd_gen #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (20),
        .REPEAT_CYCLES   (R)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .SW0       (SW0),
        .SW1       (SW1),
        .SW2       (SW2),
        .SW3       (SW3),
        .CMD_VALID (CMD_VALID),
        .CMD_CLR   (CMD_CLR),
        .CMD_SET   (CMD_SET),
        .CMD_TGL   (CMD_TGL),
        .SW_DB     (SW_DB)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         edge_n;
        logic [2:0] cmd;     // {tgl,set,clr}
    } exp_t;

    exp_t       expq[$];
    logic [3:0] hist[$];          // raw level sampled at each edge (0 while in reset)
    logic [3:0] m_db       = 4'b0000;
    logic [3:0] m_seen_prev = 4'b0000;
    bit         m_held     = 1'b0;
    int         held_edge  = 0;
    int         cyc        = -1;
    int         n_checks   = 0;
    int         n_fails    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Expected command from debounced levels: clear > set > toggle.
    function automatic void push_cmd(input int n, input logic [3:0] db);
        exp_t       e;
        logic [2:0] c;
        if (db[1])      c = 3'b001;
        else if (db[2]) c = 3'b010;
        else if (db[3]) c = 3'b100;
        else            c = 3'b000;
        if (c != 3'b000) begin
            e.edge_n = n;
            e.cmd    = c;
            expq.push_back(e);
        end
    endfunction

    // Reference model, evaluated at every rising edge.
    initial begin
        logic [3:0] seen;
        logic       v;
        bit         same;
        forever begin
            @(posedge CLK);
            cyc = cyc + 1;
            if (!RST_N) begin
                if (cyc > 0) hist[cyc-1] = 4'b0000;
                hist.push_back(4'b0000);
                m_db        = 4'b0000;
                m_seen_prev = 4'b0000;
                m_held      = 1'b0;
            end else begin
                hist.push_back({SW3, SW2, SW1, SW0});
                seen = m_db;
                if (!m_held) begin
                    if (seen[0] && !m_seen_prev[0]) begin
                        m_held    = 1'b1;
                        held_edge = cyc;
                        push_cmd(cyc, seen);
                    end
                end else if (!seen[0]) begin
                    m_held = 1'b0;
                end
`ifdef TFFERS_AUTO_REPEAT_EN
                else if (((cyc - held_edge) % R) == 0) begin
                    push_cmd(cyc, seen);
                end
`endif
                m_seen_prev = seen;
                // The synchronized sample seen at edge n is the raw level of
                // edge n-2; D identical samples differing from the stable
                // level move the stable level.
                if (cyc >= D + 1) begin
                    for (int b = 0; b < 4; b++) begin
                        v    = hist[cyc-2][b];
                        same = 1'b1;
                        for (int j = 0; j < D; j++) begin
                            if (hist[cyc-2-j][b] != v) same = 1'b0;
                        end
                        if (same && (v != m_db[b])) m_db[b] = v;
                    end
                end
            end
        end
    end

    // Monitor: compare outputs against the model on the falling edge.
    initial begin
        logic exp_valid;
        exp_t e;
        forever begin
            @(negedge CLK);
            if (cyc >= 0) begin
                check("sw_db", {28'd0, SW_DB}, {28'd0, m_db});
                exp_valid = (expq.size() > 0) && (expq[0].edge_n == cyc);
                check("cmd_valid", {31'd0, CMD_VALID}, {31'd0, exp_valid});
                if (exp_valid) begin
                    e = expq.pop_front();
                    check("cmd_bits", {29'd0, CMD_TGL, CMD_SET, CMD_CLR}, {29'd0, e.cmd});
                end else begin
                    check("cmd_bits_idle", {29'd0, CMD_TGL, CMD_SET, CMD_CLR}, 32'd0);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic press(input int hold);
        SW0 = 1'b1;
        step(hold);
        SW0 = 1'b0;
        step(12);
    endtask

    // Stimulus.
    initial begin
        int len;
        RST_N = 1'b0;
        {SW3, SW2, SW1, SW0} = 4'b1111;

        // Reset while raw switches toggle every cycle.
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            {SW3, SW2, SW1, SW0} = ~{SW3, SW2, SW1, SW0};
        end
        RST_N = 1'b1;
        {SW3, SW2, SW1, SW0} = 4'b0000;
        step(10);

        // Bouncing strobe with toggle selected.
        SW3 = 1'b1;
        step(10);
        for (int i = 0; i < 2; i++) begin
            SW0 = 1'b1; step(2);
            SW0 = 1'b0; step(2);
        end
        press(20);
        SW3 = 1'b0;

        // Priority: clear beats set and toggle; then set beats toggle.
        {SW3, SW2, SW1} = 3'b111;
        step(8);
        press(10);
        SW1 = 1'b0;
        step(8);
        press(10);

        // Empty press, then a set press.
        {SW3, SW2, SW1} = 3'b000;
        step(8);
        press(20);
        SW2 = 1'b1;
        step(8);
        press(10);

        // Long hold with toggle selected.
        {SW3, SW2, SW1} = 3'b100;
        step(8);
        press(40);

        // Selector change while held has no effect on the current press.
        {SW3, SW2, SW1} = 3'b010;
        step(8);
        SW0 = 1'b1; step(10);
        SW1 = 1'b1; step(10);
        SW0 = 1'b0; step(12);
        SW1 = 1'b0;

        // Reset in the middle of a hold with set selected.
        step(8);
        SW0 = 1'b1; step(12);
        RST_N = 1'b0; step(2);
        RST_N = 1'b1; step(15);
        SW0 = 1'b0; step(12);

        // Randomized segments: levels held for random lengths, occasional
        // strobe bounce, occasional reset.
        for (int t = 0; t < 160; t++) begin
            RST_N = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
            SW1 = ($urandom_range(0, 3) == 0);
            SW2 = ($urandom_range(0, 2) == 0);
            SW3 = ($urandom_range(0, 1) == 0);
            SW0 = ~SW0;
            len = (SW0 && $urandom_range(0, 3) == 0) ? $urandom_range(20, 40)
                                                      : $urandom_range(1, 10);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 9) == 0) SW0 = ~SW0;
                @(negedge CLK);
            end
            RST_N = 1'b1;
        end

        {SW3, SW2, SW1, SW0} = 4'b0000;
        step(20);
        check("queue_drained", expq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/tffers_cmd_gen.md
Name: tffers_cmd_gen

Overview:
- Front-end command generator that drives the clear/set/toggle flip-flop from raw board switches.
- Synchronizes and debounces four raw switches.
- Issues exactly one clean, single-cycle, priority-encoded command per debounced press of the strobe switch.
- Sits between the board switch pins and any ERS/toggle register in the system clock domain. All downstream state then runs on CLK instead of a bouncing switch edge.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive cycles a synchronized input must differ from its stable value before the stable value updates. Minimum 2.
- CNT_W, 20: debounce and repeat counter width. Must hold DEBOUNCE_CYCLES-1 and REPEAT_CYCLES-1.
- REPEAT_CYCLES, 64: auto-repeat interval in cycles. Used only with TFFERS_AUTO_REPEAT_EN.

Ports:
- CLK  in  1  system clock; all logic on its rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- SW0  in  1  raw strobe switch, asynchronous, bouncing.
- SW1  in  1  raw clear-select switch.
- SW2  in  1  raw set-select switch.
- SW3  in  1  raw toggle-select switch.
- CMD_VALID  out  1  one-cycle command pulse.
- CMD_CLR  out  1  clear command; qualified by CMD_VALID.
- CMD_SET  out  1  set command; qualified by CMD_VALID.
- CMD_TGL  out  1  toggle command; qualified by CMD_VALID.
- SW_DB  out  4  debounced levels of {SW3,SW2,SW1,SW0}; bit 0 is SW0.

Behaviour:
- Reset (RST_N low at a CLK edge):
  - Clears sync flops, SW_DB, all counters and the FSM (to IDLE).
  - Drives CMD_VALID and CMD_* to 0.
  - Takes priority over every other event, including mid-press or mid-debounce.
- Synchronizer: two flops per switch, reset value 0.
- Debounce, one independent counter per switch, evaluated at each edge:
  - sync2 == stable: counter <= 0.
  - sync2 != stable and count < DEBOUNCE_CYCLES-1: count++.
  - sync2 != stable and count == DEBOUNCE_CYCLES-1: stable <= sync2, count <= 0.
  - The counter never wraps.
  - Any bounce back to the stable value restarts the count from 0.
- Latency: raw level steady from before edge k updates SW_DB at edge k+DEBOUNCE_CYCLES+1.
- FSM states: IDLE, HELD.
  - IDLE -> HELD at the edge where SW_DB[0] is 1 and its value at the previous edge was 0 (debounced rising edge).
  - On that same edge, register the command from SW_DB[3:1] as it stands at that edge. Priority: SW_DB[1] clear > SW_DB[2] set > SW_DB[3] toggle.
  - HELD -> IDLE at the first edge where SW_DB[0] is 0.
  - No new command is issued while in HELD, except auto-repeat.
- Command outputs:
  - Registered; CMD_VALID is high for exactly one cycle, the cycle after the IDLE->HELD transition edge.
  - Exactly one of CMD_CLR/CMD_SET/CMD_TGL is high with CMD_VALID.
  - All CMD_* are 0 whenever CMD_VALID is 0.
  - If SW_DB[3:1]==0 at the strobe edge: no CMD_VALID, but the FSM still enters HELD.
- Selector switches changing during HELD: no effect until the next press (or next repeat).
- Raw strobe high through reset release: debounces 0->1 normally and produces one command. This is the intended power-up behaviour.

Optional Feature:
- Macro: TFFERS_AUTO_REPEAT_EN.
- Defined:
  - A repeat counter runs in HELD and resets to 0 on entry to HELD.
  - When it reaches REPEAT_CYCLES-1 with SW_DB[0] still 1, a new command is issued from the current SW_DB[3:1] with the same priority and the counter restarts.
  - Consecutive CMD_VALID pulses are therefore exactly REPEAT_CYCLES cycles apart.
  - Exiting HELD or reset clears the repeat counter.
- Undefined: the repeat counter and its logic are absent; one command per press.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8):
- Reset: RST_N=0 for 3 edges while raw switches toggle every cycle -> SW_DB=4'b0000, CMD_*=0 throughout; first SW_DB change no earlier than 5 edges after release.
- Bounce: SW3=1 steady; SW0 pulses 1,0,1,0 (2 cycles each), then steady 1 from before edge k -> SW_DB[0] rises at edge k+5; exactly one CMD_VALID with CMD_TGL=1 in the following cycle; no other pulses.
- Priority: SW1=SW2=SW3=1, press SW0 -> single pulse with CMD_CLR=1, CMD_SET=0, CMD_TGL=0. Repeat with SW1=0 -> CMD_SET only.
- Empty press: SW1..SW3=0, press SW0 for 20 cycles -> SW_DB[0]=1, CMD_VALID never asserted. Release, set SW2=1, press again -> one CMD_SET.
- Hold 40 cycles with SW3=1 and SW0 held 1 -> without macro, exactly one CMD_TGL. With TFFERS_AUTO_REPEAT_EN, first pulse then further pulses every 8 cycles until SW_DB[0] falls.
- Reset mid-hold: RST_N=0 for 2 edges while in HELD, with SW0=1 and SW2=1 -> outputs 0 during reset. After release, exactly one CMD_SET, CMD_VALID at edge r+6 where r is the first edge with RST_N=1.
